// File: rtl/freemode_pkg.sv
// Shared types for the free-play looper: mode encoding, default geometry and
// the event record stored in the loop buffer.
package freemode_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_REC  = 2'd1,
    MODE_PLAY = 2'd2
  } mode_e;

  localparam int unsigned NUM_KEYS_DEF = 7;
  localparam int unsigned OCT_BITS_DEF = 3;
  localparam int unsigned DUR_BITS_DEF = 8;
  localparam int unsigned NOTE_W_DEF   = $clog2(NUM_KEYS_DEF + 1);

  typedef logic [NOTE_W_DEF-1:0]   note_t;
  typedef logic [OCT_BITS_DEF-1:0] octave_t;

  typedef struct packed {
    octave_t                 octave;
    note_t                   note;
    logic [DUR_BITS_DEF-1:0] duration;
  } event_t;

endpackage

// File: rtl/freemode_looper_if.sv
// Key/button inputs and sound/light outputs of the free-play looper.
interface freemode_looper_if
  import freemode_pkg::*;
#(
  parameter int unsigned NUM_KEYS = NUM_KEYS_DEF,
  parameter int unsigned OCT_BITS = OCT_BITS_DEF,
  parameter int unsigned DEPTH    = 32
);
  localparam int unsigned NOTE_W = $clog2(NUM_KEYS + 1);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic                en;
  logic [NUM_KEYS-1:0] note_key;
  logic                oct_up;
  logic                oct_down;
  logic                rec;
  logic                play;

  logic                note_on;
  logic [NOTE_W-1:0]   note;
  logic [OCT_BITS-1:0] octave;
  logic [NUM_KEYS-1:0] led;
  logic [1:0]          mode;
  logic                full;
  logic [CNT_W-1:0]    count;

  modport master (
    output en, note_key, oct_up, oct_down, rec, play,
    input  note_on, note, octave, led, mode, full, count
  );

  modport slave (
    input  en, note_key, oct_up, oct_down, rec, play,
    output note_on, note, octave, led, mode, full, count
  );

endinterface

// File: rtl/loop_buffer.sv
// Single-clock event RAM with write pointer, wrapping read pointer and fill
// count; read data is registered from the next read pointer so it is ready early.
module loop_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_rst_i,
  input  logic                       rd_adv_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     rd_data_q, rd_data_d;
  logic             wr_ok_c;

  assign wr_ok_c = wr_en_i && (count_q != CNT_W'(DEPTH));

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (wr_ok_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(1);
    end
    if (rd_rst_i || clr_i) begin
      rd_ptr_d = '0;
    end else if (rd_adv_i) begin
      rd_ptr_d = ((CNT_W'(rd_ptr_q) + CNT_W'(1)) >= count_q) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    // Bypass so an entry written this cycle is read back correctly next cycle
    rd_data_d = (wr_ok_c && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;

endmodule

// File: rtl/freemode_looper.sv
// Free-play note request with octave control and a loop recorder that stores
// played notes as timed events and replays them continuously.
module freemode_looper
  import freemode_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = NUM_KEYS_DEF,
  parameter int unsigned OCT_BITS    = OCT_BITS_DEF,
  parameter int unsigned OCT_MAX     = 6,
  parameter int unsigned OCT_DEF     = 3,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned DUR_BITS    = DUR_BITS_DEF,
  parameter int unsigned TICK_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  freemode_looper_if.slave bus
);
  localparam int unsigned NOTE_W = $clog2(NUM_KEYS + 1);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned EVT_W  = OCT_BITS + NOTE_W + DUR_BITS;

  typedef struct packed {
    logic [OCT_BITS-1:0] octave;
    logic [NOTE_W-1:0]   note;
    logic [DUR_BITS-1:0] duration;
  } loop_evt_t;

  mode_e               mode_q, mode_d;
  logic [OCT_BITS-1:0] oct_q, oct_d;
  logic [OCT_BITS-1:0] oct_out_q, oct_out_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                note_on_q, note_on_d;
  logic [NUM_KEYS-1:0] led_q, led_d;
  logic                full_q, full_d;
  loop_evt_t           evt_q, evt_d;
  logic [DUR_BITS-1:0] rem_q, rem_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]          btn_q;

  logic                up_e_c, dn_e_c, rec_e_c, play_e_c, tick_c;
  logic [NOTE_W-1:0]   key_note_c;
  logic [OCT_BITS-1:0] oct_step_c;
  logic                wr_en_c, clr_c, rd_rst_c, rd_adv_c;
  loop_evt_t           wr_data_c, rd_evt;
  logic [CNT_W-1:0]    count;

  assign up_e_c   = bus.oct_up   && !btn_q[3];
  assign dn_e_c   = bus.oct_down && !btn_q[2];
  assign rec_e_c  = bus.rec      && !btn_q[1];
  assign play_e_c = bus.play     && !btn_q[0];
  assign tick_c   = (mode_q != MODE_IDLE) && (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));

  // Lowest pressed key wins
  always_comb begin
    key_note_c = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (bus.note_key[i]) key_note_c = NOTE_W'(i + 1);
    end
  end

  always_comb begin
    oct_step_c = oct_q;
    if (up_e_c && !dn_e_c && (oct_q != OCT_BITS'(OCT_MAX))) begin
      oct_step_c = oct_q + OCT_BITS'(1);
    end else if (dn_e_c && !up_e_c && (oct_q != '0)) begin
      oct_step_c = oct_q - OCT_BITS'(1);
    end
  end

  always_comb begin
    mode_d    = mode_q;
    oct_d     = oct_q;
    oct_out_d = oct_q;
    note_d    = '0;
    full_d    = full_q;
    evt_d     = evt_q;
    rem_d     = rem_q;
    wr_en_c   = 1'b0;
    wr_data_c = evt_q;
    clr_c     = 1'b0;
    rd_rst_c  = 1'b0;
    rd_adv_c  = 1'b0;

    if (!bus.en) begin
      mode_d   = MODE_IDLE;
      rd_rst_c = 1'b1;
    end else begin
      unique case (mode_q)
        MODE_IDLE: begin
          oct_d     = oct_step_c;
          oct_out_d = oct_step_c;
          note_d    = key_note_c;
          rd_rst_c  = 1'b1;
          if (rec_e_c) begin
            mode_d = MODE_REC;
            full_d = 1'b0;
            clr_c  = 1'b1;
            evt_d  = '{octave: oct_step_c, note: key_note_c, duration: DUR_BITS'(1)};
          end else if (play_e_c && (count != '0)) begin
            // Entry 0 is already on the read port; point the buffer at entry 1
            mode_d    = MODE_PLAY;
            oct_out_d = rd_evt.octave;
            note_d    = rd_evt.note;
            rem_d     = rd_evt.duration;
            rd_rst_c  = 1'b0;
            rd_adv_c  = 1'b1;
          end
        end
        MODE_REC: begin
          oct_d     = oct_step_c;
          oct_out_d = oct_step_c;
          note_d    = key_note_c;
          rd_rst_c  = 1'b1;
          if (rec_e_c) begin
            wr_en_c = 1'b1;
            mode_d  = MODE_IDLE;
          end else if ({oct_step_c, key_note_c} != {evt_q.octave, evt_q.note}) begin
            wr_en_c = 1'b1;
            evt_d   = '{octave: oct_step_c, note: key_note_c, duration: DUR_BITS'(1)};
          end else if (tick_c) begin
            if (evt_q.duration == '1) begin
              wr_en_c        = 1'b1;
              evt_d.duration = DUR_BITS'(1);
            end else begin
              evt_d.duration = evt_q.duration + DUR_BITS'(1);
            end
          end
          if (wr_en_c && (count == CNT_W'(DEPTH - 1))) begin
            mode_d = MODE_IDLE;
            full_d = 1'b1;
          end
        end
        MODE_PLAY: begin
          oct_out_d = oct_out_q;
          note_d    = note_q;
          if (play_e_c) begin
            mode_d    = MODE_IDLE;
            rd_rst_c  = 1'b1;
            oct_out_d = oct_q;
            note_d    = key_note_c;
          end else if (tick_c) begin
            if (rem_q <= DUR_BITS'(1)) begin
              oct_out_d = rd_evt.octave;
              note_d    = rd_evt.note;
              rem_d     = rd_evt.duration;
              rd_adv_c  = 1'b1;
            end else begin
              rem_d = rem_q - DUR_BITS'(1);
            end
          end
        end
        default: mode_d = MODE_IDLE;
      endcase
    end

    note_on_d = (note_d != '0);
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      led_d[i] = (note_d == NOTE_W'(i + 1));
    end

    if ((mode_d != mode_q) || (mode_q == MODE_IDLE) || tick_c) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_IDLE;
      oct_q      <= OCT_BITS'(OCT_DEF);
      oct_out_q  <= OCT_BITS'(OCT_DEF);
      note_q     <= '0;
      note_on_q  <= 1'b0;
      led_q      <= '0;
      full_q     <= 1'b0;
      evt_q      <= '0;
      rem_q      <= '0;
      tick_cnt_q <= '0;
      btn_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      oct_q      <= oct_d;
      oct_out_q  <= oct_out_d;
      note_q     <= note_d;
      note_on_q  <= note_on_d;
      led_q      <= led_d;
      full_q     <= full_d;
      evt_q      <= evt_d;
      rem_q      <= rem_d;
      tick_cnt_q <= tick_cnt_d;
      btn_q      <= {bus.oct_up, bus.oct_down, bus.rec, bus.play};
    end
  end

  loop_buffer #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_loop_buffer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_c),
    .wr_en_i   (wr_en_c),
    .wr_data_i (wr_data_c),
    .rd_rst_i  (rd_rst_c),
    .rd_adv_i  (rd_adv_c),
    .rd_data_o (rd_evt),
    .count_o   (count)
  );

  assign bus.note_on = note_on_q;
  assign bus.note    = note_q;
  assign bus.octave  = oct_out_q;
  assign bus.led     = led_q;
  assign bus.mode    = mode_q;
  assign bus.full    = full_q;
  assign bus.count   = count;

endmodule

// File: tb/tb_freemode_looper.sv
// Directed bench for freemode_looper with TICK_CYCLES=4 and DEPTH=4.
module tb_freemode_looper;
  import freemode_pkg::*;

  localparam int unsigned TICKS = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  freemode_looper_if #(.NUM_KEYS(7), .OCT_BITS(3), .DEPTH(DEPTH)) bus ();

  freemode_looper #(
    .NUM_KEYS    (7),
    .OCT_BITS    (3),
    .OCT_MAX     (6),
    .OCT_DEF     (3),
    .DEPTH       (DEPTH),
    .DUR_BITS    (8),
    .TICK_CYCLES (TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks sounding note (with derived note_on/led), shown octave, mode and count
  task automatic expect_out(input string tag, input int unsigned nt, input int unsigned oc,
                            input int unsigned md, input int unsigned cnt);
    logic [31:0] exp_led;
    exp_led = (nt == 0) ? 32'd0 : (32'd1 << (nt - 1));
    check({tag, ".note"},    32'(bus.note),    32'(nt));
    check({tag, ".note_on"}, 32'(bus.note_on), (nt != 0) ? 32'd1 : 32'd0);
    check({tag, ".led"},     32'(bus.led),     exp_led);
    check({tag, ".octave"},  32'(bus.octave),  32'(oc));
    check({tag, ".mode"},    32'(bus.mode),    32'(md));
    check({tag, ".count"},   32'(bus.count),   32'(cnt));
  endtask

  initial begin
    int unsigned exp_oct [5] = '{4, 5, 6, 6, 6};

    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.note_key = '0;
    bus.oct_up   = 1'b0;
    bus.oct_down = 1'b0;
    bus.rec      = 1'b0;
    bus.play     = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    expect_out("reset", 0, 3, 0, 0);
    check("reset.full", 32'(bus.full), 32'd0);

    // Key decode
    bus.note_key = 7'b0000100;
    step();
    expect_out("key3", 3, 3, 0, 0);
    bus.note_key = 7'b0000110;
    step();
    expect_out("key2", 2, 3, 0, 0);
    bus.note_key = '0;

    // Octave saturation and simultaneous buttons
    for (int k = 0; k < 5; k++) begin
      bus.oct_up = 1'b1;
      step();
      check("oct_up", 32'(bus.octave), 32'(exp_oct[k]));
      bus.oct_up = 1'b0;
      step();
    end
    bus.oct_down = 1'b1;
    step();
    check("oct_down", 32'(bus.octave), 32'd5);
    bus.oct_down = 1'b0;
    step();
    bus.oct_up   = 1'b1;
    bus.oct_down = 1'b1;
    step();
    check("oct_both", 32'(bus.octave), 32'd5);
    bus.oct_up   = 1'b0;
    bus.oct_down = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      bus.oct_down = 1'b1;
      step();
      check("oct_back", 32'(bus.octave), 32'(4 - k));
      bus.oct_down = 1'b0;
      step();
    end

    // Play with an empty buffer is ignored
    bus.play = 1'b1;
    step();
    check("play_empty.mode", 32'(bus.mode), 32'(MODE_IDLE));
    bus.play = 1'b0;
    step();

    // Record note 1 for two ticks, then note 5 for one tick
    bus.note_key = 7'b0000001;
    bus.rec      = 1'b1;
    step();
    expect_out("rec_start", 1, 3, 1, 0);
    bus.rec = 1'b0;
    for (int k = 0; k < 7; k++) step();
    bus.note_key = 7'b0010000;
    step();
    expect_out("rec_chg", 5, 3, 1, 1);
    for (int k = 0; k < 3; k++) step();
    bus.rec = 1'b1;
    step();
    expect_out("rec_stop", 5, 3, 0, 2);
    bus.rec      = 1'b0;
    bus.note_key = 7'b0000010;

    // Replay: 8 cycles of note 1, 4 of note 5, repeating; keys and rec ignored
    bus.play = 1'b1;
    step();
    expect_out("play0", 1, 3, 2, 2);
    bus.play = 1'b0;
    for (int k = 1; k < 24; k++) begin
      if (k == 5) bus.rec = 1'b1;
      if (k == 6) bus.rec = 1'b0;
      step();
      expect_out($sformatf("play%0d", k), ((k % 12) < 8) ? 1 : 5, 3, 2, 2);
    end

    // Enable low mid-play
    bus.en = 1'b0;
    step();
    expect_out("en_low", 0, 3, 0, 2);
    bus.en = 1'b1;
    step();
    expect_out("en_back", 2, 3, 0, 2);
    bus.note_key = '0;

    // Reset mid-play, with a non-default octave setting beforehand
    bus.oct_up = 1'b1;
    step();
    expect_out("oct4", 0, 4, 0, 2);
    bus.oct_up = 1'b0;
    step();
    bus.play = 1'b1;
    step();
    expect_out("play2", 1, 3, 2, 2);
    bus.play = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    expect_out("rst_play", 0, 3, 0, 0);
    check("rst_play.full", 32'(bus.full), 32'd0);
    rst = 1'b0;
    step();
    expect_out("after_rst", 0, 3, 0, 0);

    // Fill the buffer: note change every 2 cycles
    bus.note_key = 7'b0000001;
    bus.rec      = 1'b1;
    step();
    expect_out("fill_start", 1, 3, 1, 0);
    bus.rec = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.note_key = 7'(7'b0000001 << k);
      step();
      if (k < 4) expect_out($sformatf("fill%0d", k), k + 1, 3, 1, k);
    end
    expect_out("full", 5, 3, 0, 4);
    check("full.flag", 32'(bus.full), 32'd1);
    bus.note_key = '0;
    step();

    // rec and play edges together from IDLE: rec wins
    bus.rec  = 1'b1;
    bus.play = 1'b1;
    step();
    expect_out("rec_play", 0, 3, 1, 0);
    check("rec_play.full", 32'(bus.full), 32'd0);
    bus.rec  = 1'b0;
    bus.play = 1'b0;
    step();
    bus.rec = 1'b1;
    step();
    expect_out("rec_flush", 0, 3, 0, 1);
    bus.rec = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
